mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multicycle control FSM for the 8-bit TinyMIPS datapath.
- Sequences the enabled register file and the 8-bit pipeline registers: PC, four instruction-byte registers, MDR and ALU-out.
- Fetches each 32-bit instruction as four byte reads, decodes the 6-bit opcode and drives per-cycle enables and mux selects. Supports R-type, LB, SB, BEQ, J and ADDI.
- Sits between the instruction register and the datapath; it holds no data, only control state.

Parameters:
- USE_MEM_READY, 1, when 1 every memory-access state waits for mem_ready; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- op  input  6  opcode, IR bits [31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes this cycle's access.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- iord  output  1  memory address mux: 0 = PC, 1 = ALU-out.
- ir_en  output  4  one-hot enable for IR byte registers; bit0 = IR[7:0].
- pc_en  output  1  PC register enable (pc_write OR (pc_write_cond AND zero)).
- reg_write  output  1  register file write enable.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALU-out, 1 = MDR.
- alu_src_a  output  1  0 = PC, 1 = rs.
- alu_src_b  output  2  00 = rt, 01 = constant 1, 10 = imm, 11 = imm (branch offset).
- alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_source  output  2  00 = ALU result, 01 = ALU-out, 10 = jump target.
- illegal  output  1  sticky: unsupported opcode was decoded.
- state_o  output  4  current state encoding, for debug and verification.

Behaviour:
- States and encodings:
  - FETCH1 = 0, FETCH2 = 1, FETCH3 = 2, FETCH4 = 3, DECODE = 4.
  - MEMADR = 5, LBRD = 6, LBWR = 7, SBWR = 8.
  - RTYPEEX = 9, RTYPEWR = 10, BEQEX = 11, JEX = 12.
  - ADDIEX = 13, ADDIWR = 14, HALT = 15.
- Reset: state = FETCH1 and illegal = 0. All outputs are Moore, decoded from state only (pc_en additionally uses zero combinationally). They take the FETCH1 values immediately on rst assertion. rst mid-instruction aborts it; the first fetch begins on the first rising clk after rst deasserts.
- Default for every output in every state: 0, except where listed below.
- FETCHn (n = 1..4):
  - Drives mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_en = 1 << (n-1) and pc_write = 1, both gated by mem_ready.
  - Advances to FETCHn+1 (FETCH4 → DECODE) only when mem_ready = 1; otherwise holds with ir_en = 0 and pc_en = 0.
  - Net effect: PC advances by exactly 4 per instruction.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (precompute branch target). Next state by op:
  - 6'h20 (LB) or 6'h28 (SB) → MEMADR.
  - 6'h00 → RTYPEEX.
  - 6'h04 → BEQEX.
  - 6'h02 → JEX.
  - 6'h08 → ADDIEX.
  - Any other value → HALT, and illegal is set.
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state: LB → LBRD, SB → SBWR.
- LBRD: mem_read = 1, iord = 1; holds until mem_ready, then → LBWR.
- LBWR: reg_write = 1, mem_to_reg = 1, reg_dst = 0; → FETCH1.
- SBWR: mem_write = 1, iord = 1; holds until mem_ready, then → FETCH1. mem_write stays asserted while waiting.
- RTYPEEX: alu_src_a = 1, alu_src_b = 00, alu_op = 10; → RTYPEWR.
- RTYPEWR: reg_write = 1, reg_dst = 1, mem_to_reg = 0; → FETCH1.
- BEQEX: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01, pc_write_cond = 1; → FETCH1.
- JEX: pc_write = 1, pc_source = 10; → FETCH1.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00; → ADDIWR.
- ADDIWR: reg_write = 1, reg_dst = 0, mem_to_reg = 0; → FETCH1.
- HALT: all enables 0 and illegal = 1; leaves only on rst.
- Invariants:
  - ir_en is one-hot or zero.
  - mem_read and mem_write are never both 1.
  - reg_write and pc_en are never both 1.
- With USE_MEM_READY = 0, instruction latency in cycles:
  - R-type 7, ADDI 7, LB 8, SB 7, BEQ 6, J 6.

Test Plan:
- Reset mid-RTYPEEX, then release → state_o = 0 asynchronously and all outputs 0 except mem_read = 1 and alu_src_b = 01; first rising edge after release asserts ir_en = 4'b0001.
- R-type (op = 0x00) with mem_ready tied 1 → states 0,1,2,3,4,9,10,0; ir_en = 1,2,4,8 in cycles 1-4; reg_write = 1 with reg_dst = 1 in cycle 7 only.
- LB (op = 0x20) with mem_ready low for 3 cycles in LBRD → LBRD lasts 4 cycles with mem_read = 1 and iord = 1 throughout; LBWR follows with reg_write = 1 and mem_to_reg = 1.
- BEQ (op = 0x04) → in BEQEX with zero = 1, pc_en = 1 and pc_source = 01; repeated with zero = 0, pc_en = 0; both cases next state is FETCH1.
- Fetch stall: mem_ready = 0 during FETCH2 for 2 cycles → state holds at 1, ir_en = 0 and pc_en = 0 while stalled; total PC enables for the instruction = 4.
- Illegal op = 0x3F → DECODE → HALT (15), illegal = 1, no enables for 20 cycles; rst clears illegal and restarts at FETCH1.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Multicycle control FSM for the 8-bit TinyMIPS datapath. Every instruction
// is fetched as four byte reads into the IR byte registers. The opcode is
// then decoded, and the FSM walks through the execute, memory and writeback
// states of the instruction. It holds only control state; all data lives
// in the datapath.
//
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   op          : opcode IR[31:26], valid from DECODE onward
//   zero        : ALU zero flag, used by BEQ to qualify the PC write
//   mem_ready   : memory completes this cycle's access
//   mem_read    : memory read strobe
//   mem_write   : memory write strobe
//   iord        : memory address select (0 = PC, 1 = ALU-out)
//   ir_en       : one-hot IR byte enable, bit0 = IR[7:0]
//   pc_en       : PC enable
//   reg_write   : register file write enable
//   reg_dst     : destination select (0 = rt, 1 = rd)
//   mem_to_reg  : writeback select (0 = ALU-out, 1 = MDR)
//   alu_src_a   : ALU A select (0 = PC, 1 = rs)
//   alu_src_b   : ALU B select (00 rt, 01 const 1, 10 imm, 11 branch imm)
//   alu_op      : 00 add, 01 sub, 10 funct-decoded
//   pc_source   : 00 ALU result, 01 ALU-out, 10 jump target
//   illegal     : sticky flag, set when an unsupported opcode is decoded
//   state_o     : current state encoding, for debug
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter int USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic [3:0] ir_en,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14,
    HALT    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_SB    = 6'h28;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   readyEff;
  logic   fetchGo;
  logic   pcWrite;
  logic   pcWriteCond;

  // With the handshake disabled, every access is treated as completing at once.
  assign readyEff = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;

  // Fetch-side enables are also held off during reset. That way no IR byte or
  // PC update is captured while the FSM is pinned in FETCH1.
  assign fetchGo = readyEff & ~rst;

  // The state register and the sticky illegal-opcode flag both clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // This block computes the next state and the illegal flag.
  // DECODE dispatches on the opcode. MEMADR splits LB from SB.
  // HALT can only be left through reset.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      FETCH1:  if (readyEff) state_d = FETCH2;
      FETCH2:  if (readyEff) state_d = FETCH3;
      FETCH3:  if (readyEff) state_d = FETCH4;
      FETCH4:  if (readyEff) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_J:         state_d = JEX;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            state_d   = HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (op == OP_LB) ? LBRD : SBWR;
      LBRD:    if (readyEff) state_d = LBWR;
      LBWR:    state_d = FETCH1;
      SBWR:    if (readyEff) state_d = FETCH1;
      RTYPEEX: state_d = RTYPEWR;
      RTYPEWR: state_d = FETCH1;
      BEQEX:   state_d = FETCH1;
      JEX:     state_d = FETCH1;
      ADDIEX:  state_d = ADDIWR;
      ADDIWR:  state_d = FETCH1;
      HALT:    state_d = HALT;
      default: state_d = FETCH1;
    endcase
  end

  // This block decodes the Moore outputs from the current state.
  // In the fetch states the IR byte enable and the PC increment fire only on
  // the cycle the memory delivers. This makes the PC advance by exactly one
  // per byte, so by four per instruction.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_en       = 4'b0000;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_source   = 2'b00;
    unique case (state_q)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pcWrite   = fetchGo;
        unique case (state_q)
          FETCH1:  ir_en = {3'b000, fetchGo};
          FETCH2:  ir_en = {2'b00, fetchGo, 1'b0};
          FETCH3:  ir_en = {1'b0, fetchGo, 2'b00};
          default: ir_en = {fetchGo, 3'b000};
        endcase
      end
      DECODE: begin
        alu_src_b = 2'b11;
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      LBRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      LBWR: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      SBWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      RTYPEWR: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BEQEX: begin
        alu_src_a   = 1'b1;
        alu_op      = 2'b01;
        pc_source   = 2'b01;
        pcWriteCond = 1'b1;
      end
      JEX: begin
        pcWrite   = 1'b1;
        pc_source = 2'b10;
      end
      ADDIWR: begin
        reg_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pc_en   = pcWrite | (pcWriteCond & zero);
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed testbench for the TinyMIPS multicycle control FSM. The inputs are
// driven #1 after the rising edge, and the outputs are sampled before the
// next edge. Expected values are hand-derived from the state table.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic [3:0] ir_en;
  logic       pc_en;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       illegal;
  logic [3:0] state_o;

  int checkCount;
  int passCount;
  int pcEnCount;

  mips_multicycle_ctrl #(.USE_MEM_READY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_en      (ir_en),
    .pc_en      (pc_en),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and counts the result.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Drives the FSM inputs.
  task automatic applyStimulus(input logic [5:0] opV, input logic zeroV, input logic readyV);
    op        = opV;
    zero      = zeroV;
    mem_ready = readyV;
  endtask

  // Advances n rising edges and lands 1 ns after the last one.
  task automatic clockCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Packs every control output, except state and illegal-free bits, into one word.
  function automatic logic [18:0] outVec();
    return {mem_read, mem_write, iord, ir_en, pc_en, reg_write, reg_dst,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
  endfunction

  // Expected values for an R-type instruction with memory always ready.
  logic [3:0] rStates [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd0};
  logic [3:0] rIrEn   [8] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd0, 4'd0, 4'd1};
  logic       rRegWr  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    applyStimulus(6'h00, 1'b0, 1'b1);
    clockCycles(2);
    rst = 1'b0;
    #1;
    checkOutput("initState", state_o, 32'd0);

    // Reset in the middle of an R-type instruction.
    clockCycles(5);
    checkOutput("reachRtypeEx", state_o, 32'd9);
    rst = 1'b1;
    #1;
    checkOutput("asyncRstState", state_o, 32'd0);
    checkOutput("asyncRstOutputs", outVec(),
                {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 2'b01, 2'b00, 2'b00, 1'b0});
    clockCycles(1);
    checkOutput("heldInReset", state_o, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("firstFetchIrEn", ir_en, 32'd1);

    // R-type instruction run with mem_ready tied high.
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("rState%0d", i), state_o, rStates[i]);
      checkOutput($sformatf("rIrEn%0d", i), ir_en, rIrEn[i]);
      checkOutput($sformatf("rRegWr%0d", i), reg_write, rRegWr[i]);
      checkOutput($sformatf("rRegDst%0d", i), reg_dst, rRegWr[i]);
      if (i < 7) clockCycles(1);
    end

    // LB instruction with three wait cycles in LBRD.
    applyStimulus(6'h20, 1'b0, 1'b1);
    clockCycles(5);
    checkOutput("lbMemAdr", state_o, 32'd5);
    checkOutput("lbAluSrcB", alu_src_b, 32'd2);
    checkOutput("lbAluSrcA", alu_src_a, 32'd1);
    clockCycles(1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("lbRdWaitState%0d", i), state_o, 32'd6);
      checkOutput($sformatf("lbRdWaitStrobes%0d", i), {mem_read, iord}, 32'd3);
      clockCycles(1);
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("lbRdLastState", state_o, 32'd6);
    checkOutput("lbRdLastStrobes", {mem_read, iord}, 32'd3);
    clockCycles(1);
    checkOutput("lbWrState", state_o, 32'd7);
    checkOutput("lbWrCtl", {reg_write, mem_to_reg, reg_dst}, 32'b110);
    clockCycles(1);
    checkOutput("lbDone", state_o, 32'd0);

    // BEQ instruction, taken.
    applyStimulus(6'h04, 1'b1, 1'b1);
    clockCycles(5);
    checkOutput("beqTakenState", state_o, 32'd11);
    checkOutput("beqTakenPcEn", pc_en, 32'd1);
    checkOutput("beqPcSource", pc_source, 32'd1);
    checkOutput("beqAluOp", alu_op, 32'd1);
    clockCycles(1);
    checkOutput("beqTakenNext", state_o, 32'd0);

    // BEQ instruction, not taken.
    applyStimulus(6'h04, 1'b0, 1'b1);
    clockCycles(5);
    checkOutput("beqNotTakenState", state_o, 32'd11);
    checkOutput("beqNotTakenPcEn", pc_en, 32'd0);
    clockCycles(1);
    checkOutput("beqNotTakenNext", state_o, 32'd0);

    // ADDI instruction with a 2-cycle stall in FETCH2. PC enables are counted.
    applyStimulus(6'h08, 1'b0, 1'b1);
    pcEnCount = 0;
    if (pc_en) pcEnCount++;
    clockCycles(1);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput($sformatf("stallState%0d", i), state_o, 32'd1);
      checkOutput($sformatf("stallIrEn%0d", i), ir_en, 32'd0);
      checkOutput($sformatf("stallPcEn%0d", i), pc_en, 32'd0);
      if (pc_en) pcEnCount++;
      clockCycles(1);
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("stallReleaseIrEn", ir_en, 32'd2);
    for (int i = 0; i < 3; i++) begin
      if (pc_en) pcEnCount++;
      clockCycles(1);
    end
    checkOutput("addiDecode", state_o, 32'd4);
    if (pc_en) pcEnCount++;
    clockCycles(1);
    checkOutput("addiEx", state_o, 32'd13);
    if (pc_en) pcEnCount++;
    clockCycles(1);
    checkOutput("addiWrState", state_o, 32'd14);
    checkOutput("addiWrCtl", {reg_write, reg_dst, mem_to_reg}, 32'b100);
    if (pc_en) pcEnCount++;
    clockCycles(1);
    checkOutput("addiDone", state_o, 32'd0);
    checkOutput("pcEnTotal", pcEnCount, 32'd4);

    // SB instruction with one wait cycle.
    applyStimulus(6'h28, 1'b0, 1'b1);
    clockCycles(6);
    mem_ready = 1'b0;
    #1;
    checkOutput("sbWaitState", state_o, 32'd8);
    checkOutput("sbWaitStrobes", {mem_read, mem_write, iord}, 32'b011);
    clockCycles(1);
    checkOutput("sbHeld", state_o, 32'd8);
    mem_ready = 1'b1;
    clockCycles(1);
    checkOutput("sbDone", state_o, 32'd0);

    // J instruction.
    applyStimulus(6'h02, 1'b0, 1'b1);
    clockCycles(5);
    checkOutput("jState", state_o, 32'd12);
    checkOutput("jCtl", {pc_en, pc_source}, 32'b110);
    clockCycles(1);
    checkOutput("jDone", state_o, 32'd0);

    // Illegal opcode: the FSM halts and the sticky flag is set.
    applyStimulus(6'h3F, 1'b0, 1'b1);
    clockCycles(4);
    checkOutput("illegalDecode", state_o, 32'd4);
    checkOutput("illegalNotYet", illegal, 32'd0);
    clockCycles(1);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("haltState%0d", i), state_o, 32'd15);
      checkOutput($sformatf("haltOutputs%0d", i), outVec(), 32'd1);
      clockCycles(1);
    end
    rst = 1'b1;
    #1;
    checkOutput("illegalCleared", illegal, 32'd0);
    checkOutput("haltResetState", state_o, 32'd0);
    clockCycles(1);
    rst = 1'b0;
    applyStimulus(6'h00, 1'b0, 1'b1);
    clockCycles(1);
    checkOutput("restartFetch2", state_o, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
